// File: rtl/sevenseg_scan_ctrl_if.sv
// Purpose: bus bundle for the eight-digit seven-segment scan controller.
//   master : TICK, LOAD, DATA, DP, EN_MASK out; AN, SEG, DP_OUT, FRAME_DONE in
//   slave  : the reverse, used by sevenseg_scan_ctrl
//   TICK       scan strobe, one clock wide, one digit slot per pulse
//   LOAD       one-cycle strobe capturing DATA/DP/EN_MASK into the pending copy
//   DATA       eight hex nibbles, nibble i drives digit i (digit 0 rightmost)
//   DP         decimal point per digit, 1 = lit
//   EN_MASK    digit enable, 1 = digit may light
//   AN         anode drive, active-low, at most one bit low
//   SEG        cathodes {g,f,e,d,c,b,a}, active-low
//   DP_OUT     decimal-point cathode, active-low
//   FRAME_DONE one-cycle pulse at each frame start
interface sevenseg_scan_ctrl_if;
  localparam int unsigned NDIG   = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEG_W  = 7;

  logic              TICK;
  logic              LOAD;
  logic [DATA_W-1:0] DATA;
  logic [NDIG-1:0]   DP;
  logic [NDIG-1:0]   EN_MASK;
  logic [NDIG-1:0]   AN;
  logic [SEG_W-1:0]  SEG;
  logic              DP_OUT;
  logic              FRAME_DONE;

  modport master (
    output TICK, LOAD, DATA, DP, EN_MASK,
    input  AN, SEG, DP_OUT, FRAME_DONE
  );

  modport slave (
    input  TICK, LOAD, DATA, DP, EN_MASK,
    output AN, SEG, DP_OUT, FRAME_DONE
  );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Purpose: multiplexed scan controller for an eight-digit common-anode
//   seven-segment display. Each TICK ends the current digit slot; the
//   anodes are then held off for BLANK_CYCLES clocks before the next digit
//   is driven. Displayed data changes only at frame boundaries (7 -> 0).
// Ports:
//   MCLK  system clock, rising edge
//   MRST  asynchronous active-low reset
//   bus   sevenseg_scan_ctrl_if.slave (TICK, LOAD, DATA, DP, EN_MASK in;
//         AN, SEG, DP_OUT, FRAME_DONE out, all outputs registered)
// Parameter:
//   BLANK_CYCLES  inter-digit blanking length in MCLK cycles, 1..255
// Build option:
//   SEVENSEG_LZ_BLANK_EN  when defined, enabled digits above the highest
//   enabled non-zero nibble are blanked (digit 0 always shown).
module sevenseg_scan_ctrl #(
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic                 MCLK,
  input logic                 MRST,
  sevenseg_scan_ctrl_if.slave bus
);
  localparam int unsigned NDIG   = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [NDIG-1:0]   pend_dp_q, pend_dp_d;
  logic [NDIG-1:0]   pend_en_q, pend_en_d;
  logic [DATA_W-1:0] act_data_q, act_data_d;
  logic [NDIG-1:0]   act_dp_q, act_dp_d;
  logic [NDIG-1:0]   act_en_q, act_en_d;

  logic [NDIG-1:0]   an_q, an_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic              dp_out_q, dp_out_d;
  logic              frame_done_q, frame_done_d;

  logic              wrap;
  logic              digit_lit;

  // Hex to active-low {g,f,e,d,c,b,a}
  function automatic logic [SEG_W-1:0] hex_decode(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

`ifdef SEVENSEG_LZ_BLANK_EN
  // Digits above the highest enabled non-zero nibble; digit 0 never marked
  function automatic logic [NDIG-1:0] lz_mask(input logic [DATA_W-1:0] data,
                                              input logic [NDIG-1:0]   en);
    logic [NDIG-1:0] m;
    logic            seen;
    m    = '0;
    seen = 1'b0;
    for (int i = int'(NDIG) - 1; i >= 1; i--) begin
      if (en[i] && (data[i*NIB_W +: NIB_W] != 4'h0)) seen = 1'b1;
      if (!seen) m[i] = 1'b1;
    end
    return m;
  endfunction
`endif

  // State, index, counter, data copies and registered outputs
  always_ff @(posedge MCLK or negedge MRST) begin
    if (!MRST) begin
      state_q      <= ST_BLANK;
      idx_q        <= IDX_LAST;
      cnt_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      an_q         <= '1;
      seg_q        <= '1;
      dp_out_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_out_q     <= dp_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next state, data hand-over and output decode
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    wrap         = 1'b0;
    digit_lit    = 1'b0;
    an_d         = '1;
    seg_d        = '1;
    dp_out_d     = 1'b1;
    frame_done_d = 1'b0;

    if (bus.LOAD) begin
      pend_data_d = bus.DATA;
      pend_dp_d   = bus.DP;
      pend_en_d   = bus.EN_MASK;
    end

    case (state_q)
      ST_DRIVE: begin
        if (bus.TICK) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      end
      ST_BLANK: begin
        // TICK is deliberately not looked at here: slots are never queued
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          wrap    = (idx_q == IDX_LAST);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase

    // Pending already includes a same-edge LOAD, so it lands in this frame
    if (wrap) begin
      act_data_d = pend_data_d;
      act_dp_d   = pend_dp_d;
      act_en_d   = pend_en_d;
    end

    // Outputs are decoded from next-state values so they register together
    if (state_d == ST_DRIVE) begin
      digit_lit = act_en_d[idx_d];
`ifdef SEVENSEG_LZ_BLANK_EN
      if (lz_mask(act_data_d, act_en_d)[idx_d]) digit_lit = 1'b0;
`endif
      if (digit_lit) begin
        an_d  = ~(NDIG'(1) << idx_d);
        seg_d = hex_decode(act_data_d[idx_d*NIB_W +: NIB_W]);
      end
      dp_out_d = ~(act_dp_d[idx_d] & act_en_d[idx_d]);
    end

    frame_done_d = wrap;
  end

  assign bus.AN         = an_q;
  assign bus.SEG        = seg_q;
  assign bus.DP_OUT     = dp_out_q;
  assign bus.FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: behavioural model plus directed literals.
module tb_sevenseg_scan_ctrl;
  localparam int unsigned B = 4;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic MCLK = 1'b0;
  logic MRST = 1'b0;
  logic chk_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  sevenseg_scan_ctrl_if bus ();

  sevenseg_scan_ctrl #(.BLANK_CYCLES(B)) dut (
    .MCLK (MCLK),
    .MRST (MRST),
    .bus  (bus)
  );

  always #5 MCLK = ~MCLK;

  // ---------------- behavioural model ----------------
  int          m_blank_left;   // clocks of blanking still to come; 0 = driving
  int          m_digit;
  logic [31:0] m_pd, m_ad;
  logic [7:0]  m_pdp, m_adp, m_pen, m_aen;
  logic        m_fd;

  always @(posedge MCLK or negedge MRST) begin
    if (!MRST) begin
      m_blank_left = B;
      m_digit      = 7;
      m_pd = '0; m_ad = '0; m_pdp = '0; m_adp = '0; m_pen = '0; m_aen = '0;
      m_fd = 1'b0;
    end else begin
      m_fd = 1'b0;
      if (bus.LOAD) begin
        m_pd = bus.DATA; m_pdp = bus.DP; m_pen = bus.EN_MASK;
      end
      if (m_blank_left > 0) begin
        m_blank_left = m_blank_left - 1;
        if (m_blank_left == 0) begin
          m_digit = (m_digit + 1) % 8;
          if (m_digit == 0) begin
            m_ad = m_pd; m_adp = m_pdp; m_aen = m_pen;
            m_fd = 1'b1;
          end
        end
      end else if (bus.TICK) begin
        m_blank_left = B;
      end
    end
  end

  function automatic void model_outs(output logic [7:0] an, output logic [6:0] seg,
                                     output logic dpo);
    logic lit;
    int   hi;
    an  = 8'hFF;
    seg = 7'h7F;
    dpo = 1'b1;
    if (m_blank_left == 0) begin
      lit = m_aen[m_digit];
      hi  = 0;
      for (int i = 0; i < 8; i++)
        if (m_aen[i] && (m_ad[i*4 +: 4] != 4'h0)) hi = i;
`ifdef SEVENSEG_LZ_BLANK_EN
      if (m_digit > hi) lit = 1'b0;
`endif
      if (lit) begin
        an[m_digit] = 1'b0;
        seg = SEG_TAB[m_ad[m_digit*4 +: 4]];
      end
      dpo = ~(m_adp[m_digit] & m_aen[m_digit]);
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge MCLK) begin
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dpo;
    if (chk_en) begin
      model_outs(e_an, e_seg, e_dpo);
      check("AN",         32'(bus.AN),         32'(e_an));
      check("SEG",        32'(bus.SEG),        32'(e_seg));
      check("DP_OUT",     32'(bus.DP_OUT),     32'(e_dpo));
      check("FRAME_DONE", 32'(bus.FRAME_DONE), 32'(m_fd));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge MCLK);
    #2;
  endtask

  task automatic send_tick();
    bus.TICK = 1'b1;
    step();
    bus.TICK = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    bus.LOAD = 1'b1; bus.DATA = d; bus.DP = dp; bus.EN_MASK = en;
    step();
    bus.LOAD = 1'b0;
  endtask

  // Tick through slots until the model is driving digit d
  task automatic advance_to(input int d);
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (m_digit == d && m_blank_left == 0) begin
        ok = 1'b1;
        break;
      end
      send_tick();
      repeat (B + 1) step();
    end
    if (!ok) check("advance_timeout", 32'(m_digit), 32'(d));
  endtask

  initial begin
    int blank_n;
    bus.TICK = 1'b0; bus.LOAD = 1'b0; bus.DATA = '0; bus.DP = '0; bus.EN_MASK = '0;
    repeat (3) @(posedge MCLK);
    chk_en = 1'b1;
    @(negedge MCLK);
    check("rst_AN",  32'(bus.AN),         32'h0000_00FF);
    check("rst_SEG", 32'(bus.SEG),        32'h0000_007F);
    check("rst_DP",  32'(bus.DP_OUT),     32'h1);
    check("rst_FD",  32'(bus.FRAME_DONE), 32'h0);

    // First frame after reset picks up a LOAD made during the initial blank
    step();
    MRST = 1'b1;
    do_load(32'h0000_00A5, 8'h01, 8'hFF);
    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    check("first_FD",  32'(bus.FRAME_DONE), 32'h1);
    check("first_AN",  32'(bus.AN),         32'h0000_00FE);
    check("first_SEG", 32'(bus.SEG),        32'h0000_0012);
    check("first_DP",  32'(bus.DP_OUT),     32'h0);

    // Slow ticks; a second tick inside each blank must be ignored
    for (int s = 0; s < 9; s++) begin
      #2;
      repeat (100) step();
      send_tick();
      if (s == 0) begin
        blank_n = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge MCLK);
          if (bus.AN == 8'hFF) blank_n++;
          else break;
        end
        check("blank_len", 32'(blank_n), 32'd4);
        check("slot1_AN",  32'(bus.AN),  32'h0000_00FD);
        step();
      end else begin
        send_tick();
      end
    end

    // Mid-frame LOAD must not show until the next frame
    advance_to(3);
    do_load(32'h1234_5678, 8'h00, 8'hFF);
    advance_to(0);
    check("newframe_SEG", 32'(bus.SEG), 32'h0000_0000);
    check("newframe_AN",  32'(bus.AN),  32'h0000_00FE);

    // Upper digits disabled
    do_load(32'h8765_4321, 8'hF0, 8'h0F);
    advance_to(7);
    advance_to(5);
    check("dis_AN",  32'(bus.AN),     32'h0000_00FF);
    check("dis_SEG", 32'(bus.SEG),    32'h0000_007F);
    check("dis_DP",  32'(bus.DP_OUT), 32'h1);

    // Leading-zero pattern; all enabled digits lit unless the option is built in
    do_load(32'h0000_0100, 8'h00, 8'hFF);
    advance_to(7);
    advance_to(4);
`ifdef SEVENSEG_LZ_BLANK_EN
    check("lz_AN4", 32'(bus.AN), 32'h0000_00FF);
`else
    check("lz_AN4",  32'(bus.AN),  32'h0000_00EF);
    check("lz_SEG4", 32'(bus.SEG), 32'h0000_0040);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      bus.TICK = ($urandom % 16 == 0);
      if ($urandom % 40 == 0) begin
        bus.LOAD = 1'b1; bus.DATA = $urandom; bus.DP = 8'($urandom); bus.EN_MASK = 8'($urandom);
      end else begin
        bus.LOAD = 1'b0;
      end
      step();
    end
    bus.TICK = 1'b0; bus.LOAD = 1'b0;

    // Reset in the middle of digit 5, then restart at digit 0
    do_load(32'h0000_0000, 8'h00, 8'hFF);
    advance_to(7);
    advance_to(5);
    MRST = 1'b0;
    #1;
    check("midrst_AN",  32'(bus.AN),  32'h0000_00FF);
    check("midrst_SEG", 32'(bus.SEG), 32'h0000_007F);
    repeat (3) step();
    MRST = 1'b1;
    do_load(32'h0000_0000, 8'h00, 8'h01);
    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    check("restart_AN",  32'(bus.AN),         32'h0000_00FE);
    check("restart_SEG", 32'(bus.SEG),        32'h0000_0040);
    check("restart_FD",  32'(bus.FRAME_DONE), 32'h1);

    repeat (5) step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sevenseg_scan_ctrl.md
SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

Interface
REQ-001 SHALL have parameter: BLANK_CYCLES, 16, MCLK cycles of all-anodes-off inter-digit blanking; legal range 1..255.
REQ-002 SHALL have port: MCLK  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-003 SHALL have port: MRST  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: TICK  input  1  scan strobe, one MCLK wide, from the 1 kHz divider; one digit slot per TICK.
REQ-005 SHALL have port: LOAD  input  1  one-cycle strobe; captures DATA, DP, EN_MASK into pending register.
REQ-006 SHALL have port: DATA  input  32  eight hex nibbles; nibble i = digit i, digit 0 rightmost.
REQ-007 SHALL have port: DP  input  8  decimal point per digit, 1 = lit.
REQ-008 SHALL have port: EN_MASK  input  8  digit enable, 1 = digit may light.
REQ-009 SHALL have port: AN  output  8  anode drive, active-low, at most one bit low.
REQ-010 SHALL have port: SEG  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port: DP_OUT  output  1  decimal-point cathode, active-low.
REQ-012 SHALL have port: FRAME_DONE  output  1  one-cycle pulse at each frame start.

Function
REQ-013 SHALL implement two states, DRIVE and BLANK, plus 3-bit digit index idx and 8-bit blank counter.
REQ-014 In DRIVE, TICK=1 at an edge SHALL move to BLANK at that edge and register AN=8'hFF, SEG=7'h7F, DP_OUT=1.
REQ-015 BLANK SHALL last exactly BLANK_CYCLES MCLK cycles; on the final edge state=DRIVE and idx=idx+1 mod 8.
REQ-016 TICK asserted during BLANK SHALL be ignored (slot not queued).
REQ-017 In DRIVE, AN SHALL equal ~(8'b1<<idx) when active enable bit idx=1, else 8'hFF; outputs all registered.
REQ-018 SEG SHALL be hex decode of active nibble idx: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex); disabled digit SHALL drive 7'h7F.
REQ-019 DP_OUT SHALL equal ~(active DP[idx] & active EN_MASK[idx]) in DRIVE.
REQ-020 Pending register SHALL copy to active register only on idx wrap 7->0; no mid-frame change of displayed data.
REQ-021 LOAD on the same edge as the 7->0 wrap SHALL have its new values take effect for the frame starting at that edge.
REQ-022 Multiple LOADs within one frame: last one wins.
REQ-023 FRAME_DONE SHALL be high for exactly the one cycle following the 7->0 wrap edge.

Reset
REQ-024 MRST low SHALL asynchronously force: state=BLANK, idx=7, blank counter=0, AN=8'hFF, SEG=7'h7F, DP_OUT=1, FRAME_DONE=0, pending and active registers=0.
REQ-025 After MRST release, first BLANK completes after BLANK_CYCLES cycles, wraps to idx 0, loads pending, pulses FRAME_DONE.
REQ-026 MRST asserted mid-slot SHALL blank all outputs immediately, no glitch beyond the reset edge.

Configuration
REQ-027 Macro SEVENSEG_LZ_BLANK_EN: when defined, enabled digits above the highest enabled non-zero nibble SHALL be blanked (SEG=7'h7F, AN bit high, DP suppressed unless DP bit set); digit 0 never blanked.
REQ-028 Without SEVENSEG_LZ_BLANK_EN, every enabled digit SHALL display its nibble including leading zeros.

Verification
REQ-029 Reset, BLANK_CYCLES=4, LOAD DATA=32'h0000_00A5, EN_MASK=FF, DP=01 -> after 4 cycles FRAME_DONE pulse, AN=FE, SEG=12, DP_OUT=0.
REQ-030 TICK every 100 cycles -> AN sequence FE,FD,FB..7F,FE, each slot preceded by exactly 4 cycles of AN=FF; TICK during blank has no effect.
REQ-031 LOAD DATA=32'h1234_5678 while idx=3 -> digits 4..7 still show old data; new data appears only after the next FRAME_DONE.
REQ-032 EN_MASK=8'h0F -> slots 4..7 keep AN=FF, SEG=7F, timing unchanged.
REQ-033 With SEVENSEG_LZ_BLANK_EN, DATA=32'h0000_0100 -> digits 3..7 dark, digits 0..2 show 0,0,1; without macro all eight lit.
REQ-034 MRST low mid-DRIVE of idx=5 -> AN=FF same cycle; on release sequence restarts at idx 0.
